// File: rtl/jt74_ucnt.sv
// Presettable modulo-N up/down counter with 163-style clear/load priority.
// Optional output storage register enabled by JT74_UCNT_STORE_EN.
module jt74_ucnt #(
  parameter int      W    = 4,
  parameter longint  MOD  = longint'(1) << W,
  parameter longint  INIT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cl_b,
  input  logic         ld_b,
  input  logic         cep,
  input  logic         cet,
  input  logic         up,
  input  logic [W-1:0] d,
  input  logic         st,
  output logic [W-1:0] q,
  output logic [W-1:0] q_st,
  output logic         ca
);

  localparam logic [W:0]   MOD_X  = (W+1)'(MOD);
  localparam logic [W-1:0] Q_MAX  = W'(MOD - 1);
  localparam logic [W-1:0] Q_INIT = W'(INIT);

  logic [W:0]   q_x;
  logic [W:0]   inc_x;
  logic [W:0]   dec_x;
  logic [W-1:0] q_up;
  logic [W-1:0] q_dn;
  logic [W-1:0] q_ld;
  logic         at_max;
  logic         at_min;

  // Widened by one bit so MOD == 2**W compares without overflow
  assign q_x    = {1'b0, q};
  assign inc_x  = q_x + 1'b1;
  assign dec_x  = q_x - 1'b1;
  assign at_max = (q == Q_MAX);
  assign at_min = (q == '0);

  assign q_up = at_max ? '0 : inc_x[W-1:0];
  assign q_dn = at_min ? Q_MAX : dec_x[W-1:0];
  assign q_ld = ({1'b0, d} >= MOD_X) ? Q_MAX : d;

  assign ca = cet & (up ? at_max : at_min);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= Q_INIT;
    end else begin
      priority case (1'b1)
        !cl_b:      q <= '0;
        !ld_b:      q <= q_ld;
        cep && cet: q <= up ? q_up : q_dn;
        default:    q <= q;
      endcase
    end
  end

`ifdef JT74_UCNT_STORE_EN
  always_ff @(posedge clk) begin
    if (rst)     q_st <= '0;
    else if (st) q_st <= q;
  end
`else
  logic unused_st;
  assign unused_st = st;
  assign q_st      = q;
`endif

endmodule

// File: tb/tb_jt74_ucnt.sv
// Directed bench for jt74_ucnt: modulo wrap, down count, load
// saturation, clear priority, cascade and storage register.
module tb_jt74_ucnt;

`ifdef JT74_UCNT_STORE_EN
  localparam bit STORE = 1'b1;
`else
  localparam bit STORE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: W=4 MOD=16 INIT=0
  logic       rst_a = 1'b1, cl_a = 1'b1, ld_a = 1'b1;
  logic       cep_a = 1'b0, cet_a = 1'b0, up_a = 1'b1, st_a = 1'b0;
  logic [3:0] d_a = '0, q_a, qst_a;
  logic       ca_a;

  // B: W=4 MOD=10 INIT=5
  logic       rst_b = 1'b1, cl_b = 1'b1, ld_b = 1'b1;
  logic       cep_b = 1'b0, cet_b = 1'b0, up_b = 1'b1, st_b = 1'b0;
  logic [3:0] d_b = '0, q_b, qst_b;
  logic       ca_b;

  // C: two cascaded W=4 counters
  logic       rst_c = 1'b1, cep_c = 1'b0, up_c = 1'b1;
  logic [3:0] q_c0, q_c1, qst_c0, qst_c1;
  logic       ca_c0, ca_c1;

  jt74_ucnt #(.W(4), .MOD(16), .INIT(0)) u_a (
    .clk(clk), .rst(rst_a), .cl_b(cl_a), .ld_b(ld_a),
    .cep(cep_a), .cet(cet_a), .up(up_a), .d(d_a), .st(st_a),
    .q(q_a), .q_st(qst_a), .ca(ca_a)
  );

  jt74_ucnt #(.W(4), .MOD(10), .INIT(5)) u_b (
    .clk(clk), .rst(rst_b), .cl_b(cl_b), .ld_b(ld_b),
    .cep(cep_b), .cet(cet_b), .up(up_b), .d(d_b), .st(st_b),
    .q(q_b), .q_st(qst_b), .ca(ca_b)
  );

  jt74_ucnt #(.W(4)) u_c0 (
    .clk(clk), .rst(rst_c), .cl_b(1'b1), .ld_b(1'b1),
    .cep(cep_c), .cet(1'b1), .up(up_c), .d(4'h0), .st(1'b0),
    .q(q_c0), .q_st(qst_c0), .ca(ca_c0)
  );

  jt74_ucnt #(.W(4)) u_c1 (
    .clk(clk), .rst(rst_c), .cl_b(1'b1), .ld_b(1'b1),
    .cep(cep_c), .cet(ca_c0), .up(up_c), .d(4'h0), .st(1'b0),
    .q(q_c1), .q_st(qst_c1), .ca(ca_c1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset all instances
    tick();
    check("a_rst_q", q_a, 0);
    check("a_rst_qst", qst_a, 0);
    check("b_rst_q", q_b, 5);
    check("c_rst_q", {q_c1, q_c0}, 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // 1: up count through the modulus
    cep_a = 1'b1; cet_a = 1'b1; up_a = 1'b1;
    #1;
    for (int i = 1; i <= 17; i++) begin
      check("t1_ca", ca_a, ((i - 1) % 16) == 15);
      tick();
      check("t1_q", q_a, i % 16);
    end

    // 5: storage register captures pre-edge q
    repeat (4) tick();
    check("t5_q5", q_a, 5);
    st_a = 1'b1;
    tick();
    st_a = 1'b0;
    check("t5_q6", q_a, 6);
    check("t5_st", qst_a, STORE ? 5 : 6);
    tick();
    check("t5_st_hold", qst_a, STORE ? 5 : 7);
    cl_a = 1'b0;
    tick();
    cl_a = 1'b1;
    check("t5_clr_q", q_a, 0);
    check("t5_clr_st", qst_a, STORE ? 5 : 0);

    // 6: reset mid-count on A
    repeat (7) tick();
    check("t6a_q7", q_a, 7);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("t6a_rst_q", q_a, 0);
    check("t6a_rst_st", qst_a, 0);
    tick();
    check("t6a_resume", q_a, 1);
    check("t6a_st_after", qst_a, STORE ? 0 : 1);

    // 2: down count on MOD=10
    cl_b = 1'b0;
    tick();
    cl_b = 1'b1;
    check("t2_clr", q_b, 0);
    up_b = 1'b0; cet_b = 1'b1; cep_b = 1'b0;
    #1;
    check("t2_ca_dn", ca_b, 1);
    cet_b = 1'b0;
    #1;
    check("t2_ca_cet0", ca_b, 0);
    up_b = 1'b1; cet_b = 1'b1;
    #1;
    check("t2_ca_up", ca_b, 0);
    up_b = 1'b0; cep_b = 1'b1;
    #1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("t2_q", q_b, (10 - i) % 10);
      check("t2_ca", ca_b, i == 10);
    end

    // 3: load saturation and clear priority
    cep_b = 1'b0; up_b = 1'b1;
    ld_b = 1'b0; d_b = 4'hC;
    tick();
    check("t3_sat_c", q_b, 9);
    check("t3_ca9", ca_b, 1);
    d_b = 4'h3;
    tick();
    check("t3_ld3", q_b, 3);
    d_b = 4'hA;
    tick();
    check("t3_sat_a", q_b, 9);
    d_b = 4'h7; cl_b = 1'b0;
    tick();
    check("t3_clr_ld", q_b, 0);
    cl_b = 1'b1; d_b = 4'h4; cep_b = 1'b1;
    tick();
    ld_b = 1'b1;
    check("t3_ld_cnt", q_b, 4);

    // 6: reset mid-count on B, INIT=5
    repeat (3) tick();
    check("t6b_q7", q_b, 7);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check("t6b_rst_q", q_b, 5);
    check("t6b_rst_st", qst_b, STORE ? 0 : 5);
    tick();
    check("t6b_resume", q_b, 6);
    repeat (3) tick();
    check("t6b_q9", q_b, 9);
    check("t6b_ca9", ca_b, 1);
    tick();
    check("t6b_wrap", q_b, 0);

    // 4: cascade, 300 up then 45 down
    cep_c = 1'b1; up_c = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 16) check("t4_q16", {q_c1, q_c0}, 8'h10);
    end
    check("t4_q300", {q_c1, q_c0}, 8'h2C);
    up_c = 1'b0;
    repeat (45) tick();
    check("t4_borrow", {q_c1, q_c0}, 8'hFF);
    check("t4_ca1", ca_c1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
